// File: rtl/enum_rr_arbiter.sv
// Round-robin arbiter sharing one pkg::enum_t command channel across NUM_REQ requesters.
// Optional feature macro: ENUM_ARB_LEGAL_CHECK_EN drops out-of-enum codes and pulses `illegal`.
package pkg;
  typedef enum logic [7:0] {
    ONE   = 8'h00,
    TWO   = 8'h01,
    THREE = 8'h02
  } enum_t;
  typedef enum_t alias_t;
endpackage

module enum_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic       [NUM_REQ-1:0]  req_valid,
  input  pkg::enum_t [NUM_REQ-1:0]  req_code,
  output logic       [NUM_REQ-1:0]  req_ready,
  output logic                      out_valid,
  output pkg::alias_t               out_code,
  output logic       [SRC_W-1:0]    out_src,
  input  logic                      out_ready,
  output logic       [CNT_W-1:0]    cnt_one,
  output logic       [CNT_W-1:0]    cnt_two,
  output logic       [CNT_W-1:0]    cnt_three,
  output logic                      illegal
);

  // Requester index k positions after p, wrapping at NUM_REQ.
  function automatic logic [SRC_W-1:0] rot_idx(input logic [SRC_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SRC_W'(s);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  pkg::alias_t      out_code_q, out_code_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;
  logic [CNT_W-1:0] cnt_one_q, cnt_one_d;
  logic [CNT_W-1:0] cnt_two_q, cnt_two_d;
  logic [CNT_W-1:0] cnt_three_q, cnt_three_d;

  logic             found;
  logic [SRC_W-1:0] winner;
  logic             slot_free;
  logic             accept;
  logic             load;
  pkg::enum_t       win_code;

  // Winner search depends only on valids and pointer, keeping req_code off the ready path.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[rot_idx(ptr_q, k)]) begin
        found  = 1'b1;
        winner = rot_idx(ptr_q, k);
      end
    end
  end

  assign slot_free = !out_valid_q || out_ready;
  assign accept    = found && slot_free && !rst;
  assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;
  assign win_code  = req_code[winner];

`ifdef ENUM_ARB_LEGAL_CHECK_EN
  logic illegal_q, illegal_d;
  assign load      = 8'(win_code) < 8'h03;
  assign illegal_d = accept && !load;
  assign illegal   = illegal_q;
`else
  assign load    = 1'b1;
  assign illegal = 1'b0;
`endif

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q && !out_ready;
    out_code_d  = out_code_q;
    out_src_d   = out_src_q;
    cnt_one_d   = cnt_one_q;
    cnt_two_d   = cnt_two_q;
    cnt_three_d = cnt_three_q;
    if (accept) begin
      ptr_d = (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      if (load) begin
        out_valid_d = 1'b1;
        out_code_d  = win_code;
        out_src_d   = winner;
      end
      case (win_code)
        pkg::ONE:   cnt_one_d   = sat_inc(cnt_one_q);
        pkg::TWO:   cnt_two_d   = sat_inc(cnt_two_q);
        pkg::THREE: cnt_three_d = sat_inc(cnt_three_q);
        default:    ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= pkg::ONE;
      out_src_q   <= '0;
      cnt_one_q   <= '0;
      cnt_two_q   <= '0;
      cnt_three_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_src_q   <= out_src_d;
      cnt_one_q   <= cnt_one_d;
      cnt_two_q   <= cnt_two_d;
      cnt_three_q <= cnt_three_d;
    end
  end

`ifdef ENUM_ARB_LEGAL_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
`endif

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_src   = out_src_q;
  assign cnt_one   = cnt_one_q;
  assign cnt_two   = cnt_two_q;
  assign cnt_three = cnt_three_q;

endmodule

// File: tb/tb_enum_rr_arbiter.sv
// Scoreboard bench for enum_rr_arbiter: a cycle model predicts grants and counters,
// a separate monitor pops expected slot contents whenever the DUT presents them.
module tb_enum_rr_arbiter;
  localparam int N = 4;
  localparam int CW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic       [N-1:0]   req_valid;
  pkg::enum_t [N-1:0]   req_code;
  logic       [N-1:0]   req_ready;
  logic                 out_valid;
  pkg::alias_t          out_code;
  logic       [1:0]     out_src;
  logic                 out_ready;
  logic       [CW-1:0]  cnt_one, cnt_two, cnt_three;
  logic                 illegal;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [7:0] code; int src; } item_t;
  item_t sb[$];

  // Reference state
  int m_ptr = 0;
  bit m_valid = 0;
  bit m_ill = 0;
  int m_cnt[3] = '{0, 0, 0};

  enum_rr_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code),
    .req_ready(req_ready), .out_valid(out_valid), .out_code(out_code),
    .out_src(out_src), .out_ready(out_ready), .cnt_one(cnt_one),
    .cnt_two(cnt_two), .cnt_three(cnt_three), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: grant = valid requester with smallest rotational distance from ptr.
  always @(negedge clk) begin
    int win, best;
    logic [N-1:0] exp_ready;
    bit free;
    logic [7:0] c;
    item_t it;
    win = -1; best = N; exp_ready = '0;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && ((i - m_ptr + N) % N) < best) begin
        best = (i - m_ptr + N) % N;
        win  = i;
      end
    free = !m_valid || out_ready;
    if (!rst && win >= 0 && free) exp_ready[win] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("cnt_one", 32'(cnt_one), m_cnt[0]);
    check("cnt_two", 32'(cnt_two), m_cnt[1]);
    check("cnt_three", 32'(cnt_three), m_cnt[2]);
    check("illegal", 32'(illegal), 32'(m_ill));
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_ill = 0; m_cnt = '{0, 0, 0};
      sb.delete();
    end else begin
      m_ill = 0;
      if (m_valid && out_ready) m_valid = 0;
      if (exp_ready != '0) begin
        c = 8'(req_code[win]);
        m_ptr = (win + 1) % N;
        if (c < 8'd3 && m_cnt[c] < 65535) m_cnt[c] = m_cnt[c] + 1;
`ifdef ENUM_ARB_LEGAL_CHECK_EN
        if (c < 8'd3) begin
          it.code = c; it.src = win; sb.push_back(it); m_valid = 1;
        end else m_ill = 1;
`else
        it.code = c; it.src = win; sb.push_back(it); m_valid = 1;
`endif
      end
    end
  end

  // Monitor: whatever sits in the slot must be the oldest predicted item.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(out_valid), 32'd0);
      end else begin
        check("sb_code", 32'(8'(out_code)), 32'(sb[0].code));
        check("sb_src", 32'(out_src), sb[0].src);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] c1, c2, c3;
    rst = 1'b1; req_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) req_code[i] = pkg::ONE;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_code", 32'(8'(out_code)), 0);
    check("rst_out_src", 32'(out_src), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_cnt_one", 32'(cnt_one), 0);
    check("rst_illegal", 32'(illegal), 0);

    // All four valid: round-robin 0,1,2,3,0
    req_code[0] = pkg::ONE; req_code[1] = pkg::TWO;
    req_code[2] = pkg::THREE; req_code[3] = pkg::ONE;
    req_valid = 4'hF; #1;
    check("rr_first_ready", 32'(req_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_src", 32'(out_src), k % 4);
    end
    req_valid = '0;
    check("rr_cnt_one", 32'(cnt_one), 3);
    check("rr_cnt_two", 32'(cnt_two), 1);
    check("rr_cnt_three", 32'(cnt_three), 1);
    step();

    // Stall with requester 2 holding TWO
    req_valid = 4'b0100; req_code[2] = pkg::TWO; out_ready = 1'b0; #1;
    check("stall_grant", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0001; req_code[0] = pkg::ONE;
    repeat (3) begin
      #1;
      check("stall_ready", 32'(req_ready), 0);
      check("stall_code", 32'(8'(out_code)), 32'h01);
      check("stall_src", 32'(out_src), 2);
      step();
    end
    req_valid = '0; out_ready = 1'b1;
    step();
    check("stall_drain", 32'(out_valid), 0);

    // ptr to 2, then requesters 1 and 3: grant 3, 1, 3
    req_valid = 4'b0010; step();
    req_valid = 4'b1010; step();
    check("wrap_a", 32'(out_src), 3);
    step();
    check("wrap_b", 32'(out_src), 1);
    step();
    check("wrap_c", 32'(out_src), 3);
    req_valid = '0; step();

    // Out-of-enum code from requester 0 (ptr is 0 here)
    c1 = cnt_one; c2 = cnt_two; c3 = cnt_three;
    req_valid = 4'b0001; req_code[0] = pkg::enum_t'(8'h07); #1;
    check("ill_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("ill_cnt_one", 32'(cnt_one), 32'(c1));
    check("ill_cnt_two", 32'(cnt_two), 32'(c2));
    check("ill_cnt_three", 32'(cnt_three), 32'(c3));
`ifdef ENUM_ARB_LEGAL_CHECK_EN
    check("ill_pulse", 32'(illegal), 1);
    check("ill_no_load", 32'(out_valid), 0);
    step();
    check("ill_pulse_end", 32'(illegal), 0);
`else
    check("fwd_code", 32'(8'(out_code)), 32'h07);
    check("fwd_valid", 32'(out_valid), 1);
    step();
`endif

    // Reset in mid-traffic
    for (int i = 0; i < N; i++) req_code[i] = pkg::TWO;
    req_valid = 4'hF; step(); step();
    rst = 1'b1; #1;
    check("rst_ready_forced", 32'(req_ready), 0);
    step();
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_cnt", 32'(cnt_two), 0);
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) req_code[i] = pkg::enum_t'(8'($urandom_range(0, 4)));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Saturation of cnt_three
    rst = 1'b1; req_valid = '0; out_ready = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) req_code[i] = pkg::THREE;
    req_valid = 4'hF;
    repeat (65535) step();
    check("sat_reach", 32'(cnt_three), 32'hFFFF);
    step();
    check("sat_hold", 32'(cnt_three), 32'hFFFF);
    req_valid = '0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
